// File: rtl/ctrl_mc_pkg.sv
// Shared encodings for the multicycle RV32I control unit: opcodes, FSM states,
// datapath mux selects and the bundled control-word type.
package ctrl_mc_pkg;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMRD    = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWR    = 4'd5,
      S_EXEC_R   = 4'd6,
      S_EXEC_I   = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_JALR_ADR = 4'd10,
      S_JAL      = 4'd11,
      S_UPPER    = 4'd12,
      S_TRAP     = 4'd13
   } state_t;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;
   localparam logic [1:0] SRCA_ZERO  = 2'b11;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_MDR    = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_U = 3'b011;
   localparam logic [2:0] IMM_J = 3'b100;

   typedef struct packed {
      logic       pc_write;
      logic       adr_src;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       reg_write;
      logic       branch;
      logic [1:0] src_a;
      logic [1:0] src_b;
      logic [1:0] result_src;
      logic [1:0] alu_op;
   } ctrl_t;

   // Unknown opcodes fall back to the I format; their extended value is never used.
   function automatic logic [2:0] imm_sel(input logic [6:0] op);
      case (op)
         OP_STORE:         return IMM_S;
         OP_BRANCH:        return IMM_B;
         OP_LUI, OP_AUIPC: return IMM_U;
         OP_JAL:           return IMM_J;
         default:          return IMM_I;
      endcase
   endfunction

endpackage

// File: rtl/cu_wait_timer.sv
// Saturating stall counter for the bus wait states; flags expiry when the
// count reaches a non-zero limit.
module cu_wait_timer #(
   parameter int TO_W = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clear,
   input  logic            count,
   input  logic [TO_W-1:0] max,
   output logic            expired
);

   logic [TO_W-1:0] r_count;

   // NOTE: sequential state always uses non-blocking assignments so every
   // register samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         r_count <= '0;
      end else if (count && (r_count != max)) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign expired = (max != '0) && (r_count == max);

endmodule

// File: rtl/control_unit_mc.sv
// Multicycle RV32I control unit: Moore FSM sequencing fetch/decode/execute/
// memory/write-back with a bus-ready handshake, wait-state timeout and sticky errors.
module control_unit_mc
   import ctrl_mc_pkg::*;
#(
   parameter bit MEM_HANDSHAKE = 1'b1,
   parameter int WAIT_TIMEOUT  = 15,
   parameter bit ILLEGAL_TRAP  = 1'b1,
   parameter int TO_W          = (WAIT_TIMEOUT > 0) ? $clog2(WAIT_TIMEOUT + 1) : 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] opCode,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic       Branch,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUOp,
   output logic [2:0] immSel,
   output logic       illegal,
   output logic       bus_err,
   output logic [3:0] state_dbg
);

   state_t r_state;
   state_t w_next;
   ctrl_t  w_ctrl;
   logic   r_illegal;
   logic   r_bus_err;
   logic   w_ready;
   logic   w_wait_state;
   logic   w_expired;
   logic   w_timeout;
   logic   w_set_illegal;

   assign w_ready      = MEM_HANDSHAKE ? mem_ready : 1'b1;
   assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
   // A ready arriving on the expiry cycle completes normally instead of trapping.
   assign w_timeout    = w_wait_state && !w_ready && w_expired;

   cu_wait_timer #(
      .TO_W (TO_W)
   ) u_wait_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (w_next != r_state),
      .count   (w_wait_state && !w_ready),
      .max     (TO_W'(WAIT_TIMEOUT)),
      .expired (w_expired)
   );

   // NOTE: every combinational output gets a default first so no path
   // through the case statement can infer a latch.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_FETCH:    if (w_ready) w_next = S_DECODE;
         S_DECODE: begin
            case (opCode)
               OP_LOAD, OP_STORE: w_next = S_MEMADR;
               OP_R:              w_next = S_EXEC_R;
               OP_IMM:            w_next = S_EXEC_I;
               OP_BRANCH:         w_next = S_BRANCH;
               OP_JAL:            w_next = S_JAL;
               OP_JALR:           w_next = S_JALR_ADR;
               OP_LUI, OP_AUIPC:  w_next = S_UPPER;
               default:           w_next = ILLEGAL_TRAP ? S_TRAP : S_FETCH;
            endcase
         end
         S_MEMADR:   w_next = (opCode == OP_STORE) ? S_MEMWR : S_MEMRD;
         S_MEMRD:    if (w_ready) w_next = S_MEMWB;
         S_MEMWB:    w_next = S_FETCH;
         S_MEMWR:    if (w_ready) w_next = S_FETCH;
         S_EXEC_R:   w_next = S_ALUWB;
         S_EXEC_I:   w_next = S_ALUWB;
         S_ALUWB:    w_next = S_FETCH;
         S_BRANCH:   w_next = S_FETCH;
         S_JALR_ADR: w_next = S_JAL;
         S_JAL:      w_next = S_ALUWB;
         S_UPPER:    w_next = S_ALUWB;
         S_TRAP:     w_next = S_TRAP;
         default:    w_next = S_FETCH;
      endcase
      if (w_timeout) w_next = S_TRAP;
   end

   assign w_set_illegal = (r_state == S_DECODE) && (w_next == S_TRAP);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_FETCH;
         r_illegal <= 1'b0;
         r_bus_err <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_set_illegal) r_illegal <= 1'b1;
         if (w_timeout)     r_bus_err <= 1'b1;
      end
   end

   always_comb begin
      w_ctrl = '0;
      case (r_state)
         S_FETCH: begin
            w_ctrl.mem_read   = 1'b1;
            w_ctrl.src_a      = SRCA_PC;
            w_ctrl.src_b      = SRCB_FOUR;
            w_ctrl.alu_op     = ALUOP_ADD;
            w_ctrl.result_src = RES_ALU;
            w_ctrl.ir_write   = w_ready;
            w_ctrl.pc_write   = w_ready;
         end
         S_DECODE: begin
            w_ctrl.src_a = SRCA_OLDPC;
            w_ctrl.src_b = SRCB_IMM;
         end
         S_MEMADR, S_JALR_ADR: begin
            w_ctrl.src_a = SRCA_RS1;
            w_ctrl.src_b = SRCB_IMM;
         end
         S_MEMRD: begin
            w_ctrl.mem_read = 1'b1;
            w_ctrl.adr_src  = 1'b1;
         end
         S_MEMWB: begin
            w_ctrl.result_src = RES_MDR;
            w_ctrl.reg_write  = 1'b1;
         end
         S_MEMWR: begin
            w_ctrl.mem_write = 1'b1;
            w_ctrl.adr_src   = 1'b1;
         end
         S_EXEC_R: begin
            w_ctrl.src_a  = SRCA_RS1;
            w_ctrl.src_b  = SRCB_RS2;
            w_ctrl.alu_op = ALUOP_FUNCT;
         end
         S_EXEC_I: begin
            w_ctrl.src_a  = SRCA_RS1;
            w_ctrl.src_b  = SRCB_IMM;
            w_ctrl.alu_op = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            w_ctrl.result_src = RES_ALUOUT;
            w_ctrl.reg_write  = 1'b1;
         end
         S_BRANCH: begin
            w_ctrl.src_a      = SRCA_RS1;
            w_ctrl.src_b      = SRCB_RS2;
            w_ctrl.alu_op     = ALUOP_SUB;
            w_ctrl.result_src = RES_ALUOUT;
            w_ctrl.branch     = 1'b1;
         end
         S_JAL: begin
            w_ctrl.src_a      = SRCA_OLDPC;
            w_ctrl.src_b      = SRCB_FOUR;
            w_ctrl.result_src = RES_ALUOUT;
            w_ctrl.pc_write   = 1'b1;
         end
         S_UPPER: begin
            w_ctrl.src_a = (opCode == OP_LUI) ? SRCA_ZERO : SRCA_OLDPC;
            w_ctrl.src_b = SRCB_IMM;
         end
         default: w_ctrl = '0;
      endcase
      // Reset masks everything so an abandoned instruction leaves no side effect.
      if (rst) w_ctrl = '0;
   end

   assign PCWrite   = w_ctrl.pc_write;
   assign AdrSrc    = w_ctrl.adr_src;
   assign MemRead   = w_ctrl.mem_read;
   assign MemWrite  = w_ctrl.mem_write;
   assign IRWrite   = w_ctrl.ir_write;
   assign RegWrite  = w_ctrl.reg_write;
   assign Branch    = w_ctrl.branch;
   assign ALUSrcA   = w_ctrl.src_a;
   assign ALUSrcB   = w_ctrl.src_b;
   assign ResultSrc = w_ctrl.result_src;
   assign ALUOp     = w_ctrl.alu_op;
   assign immSel    = rst ? 3'b000 : imm_sel(opCode);
   assign illegal   = r_illegal & ~rst;
   assign bus_err   = r_bus_err & ~rst;
   assign state_dbg = rst ? 4'(S_FETCH) : 4'(r_state);

endmodule

// File: tb/tb_control_unit_mc.sv
// Directed bench for control_unit_mc: per-cycle state/control vectors for each
// instruction class, handshake stalls, timeout, illegal opcode and reset abort.
module tb_control_unit_mc;
   import ctrl_mc_pkg::*;

   // Control word layout: PCW AdrSrc MR MW IRW RW Br | A B Res Op
   localparam logic [14:0] C_ZERO    = 15'b0000000_00_00_00_00;
   localparam logic [14:0] C_FETCH_R = 15'b1010100_00_10_10_00;
   localparam logic [14:0] C_DECODE  = 15'b0000000_01_01_00_00;
   localparam logic [14:0] C_EXEC_R  = 15'b0000000_10_00_00_10;
   localparam logic [14:0] C_ALUWB   = 15'b0000010_00_00_00_00;
   localparam logic [14:0] C_MEMADR  = 15'b0000000_10_01_00_00;
   localparam logic [14:0] C_MEMRD   = 15'b0110000_00_00_00_00;
   localparam logic [14:0] C_MEMWB   = 15'b0000010_00_00_01_00;
   localparam logic [14:0] C_MEMWR   = 15'b0101000_00_00_00_00;
   localparam logic [14:0] C_BRANCH  = 15'b0000001_10_00_00_01;
   localparam logic [14:0] C_JAL     = 15'b1000000_01_10_00_00;
   localparam logic [14:0] C_LUI     = 15'b0000000_11_01_00_00;
   localparam logic [14:0] C_AUIPC   = 15'b0000000_01_01_00_00;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [6:0] opCode = 7'b0100011;
   logic mem_ready = 1'b1;
   int n_pass = 0;
   int n_total = 0;

   logic PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, RegWrite, Branch, illegal, bus_err;
   logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ALUOp;
   logic [2:0] immSel;
   logic [3:0] state_dbg;
   logic PCWrite2, AdrSrc2, MemRead2, MemWrite2, IRWrite2, RegWrite2, Branch2, illegal2, bus_err2;
   logic [1:0] ALUSrcA2, ALUSrcB2, ResultSrc2, ALUOp2;
   logic [2:0] immSel2;
   logic [3:0] state_dbg2;
   logic [14:0] ctrl1, ctrl2;

   assign ctrl1 = {PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, RegWrite, Branch,
                   ALUSrcA, ALUSrcB, ResultSrc, ALUOp};
   assign ctrl2 = {PCWrite2, AdrSrc2, MemRead2, MemWrite2, IRWrite2, RegWrite2, Branch2,
                   ALUSrcA2, ALUSrcB2, ResultSrc2, ALUOp2};

   always #5 clk = ~clk;

   control_unit_mc #(.MEM_HANDSHAKE(1'b1), .WAIT_TIMEOUT(15), .ILLEGAL_TRAP(1'b1)) dut (
      .clk(clk), .rst(rst), .opCode(opCode), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemRead(MemRead), .MemWrite(MemWrite),
      .IRWrite(IRWrite), .RegWrite(RegWrite), .Branch(Branch), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ALUOp(ALUOp), .immSel(immSel),
      .illegal(illegal), .bus_err(bus_err), .state_dbg(state_dbg)
   );

   control_unit_mc #(.MEM_HANDSHAKE(1'b1), .WAIT_TIMEOUT(15), .ILLEGAL_TRAP(1'b0)) dut_nop (
      .clk(clk), .rst(rst), .opCode(opCode), .mem_ready(mem_ready),
      .PCWrite(PCWrite2), .AdrSrc(AdrSrc2), .MemRead(MemRead2), .MemWrite(MemWrite2),
      .IRWrite(IRWrite2), .RegWrite(RegWrite2), .Branch(Branch2), .ALUSrcA(ALUSrcA2),
      .ALUSrcB(ALUSrcB2), .ResultSrc(ResultSrc2), .ALUOp(ALUOp2), .immSel(immSel2),
      .illegal(illegal2), .bus_err(bus_err2), .state_dbg(state_dbg2)
   );

   // Step entry: {mem_ready, expected state, expected control word}
   function automatic logic [19:0] e(input logic rdy, input state_t st, input logic [14:0] c);
      return {rdy, 4'(st), c};
   endfunction

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      mem_ready = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      mem_ready = 1'b1;
      opCode = OP_STORE;
      #1;
      n_total++;
      if ({state_dbg, ctrl1, immSel, illegal, bus_err} !== {4'(S_FETCH), 15'd0, 3'd0, 2'd0})
         $display("FAIL reset_outputs: got st=%0d ctrl=%b imm=%b ill=%b berr=%b, want st=0 all zero",
                  state_dbg, ctrl1, immSel, illegal, bus_err);
      else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_total++;
      if ({state_dbg, ctrl1, ctrl2} !== {4'(S_FETCH), C_FETCH_R, C_FETCH_R})
         $display("FAIL reset_release: got st=%0d ctrl=%b ctrl2=%b, want st=0 ctrl=%b",
                  state_dbg, ctrl1, ctrl2, C_FETCH_R);
      else n_pass++;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_r_type();
      logic [19:0] seq [4];
      seq = '{e(1, S_FETCH, C_FETCH_R), e(1, S_DECODE, C_DECODE),
              e(1, S_EXEC_R, C_EXEC_R), e(1, S_ALUWB, C_ALUWB)};
      opCode = OP_R;
      foreach (seq[i]) begin
         mem_ready = seq[i][19];
         #1;
         n_total++;
         if ({state_dbg, ctrl1} !== seq[i][18:0])
            $display("FAIL r_type step%0d: got st=%0d ctrl=%b, want st=%0d ctrl=%b",
                     i, state_dbg, ctrl1, seq[i][18:15], seq[i][14:0]);
         else n_pass++;
         @(negedge clk);
      end
   endtask

   task automatic test_lw_wait();
      logic [19:0] seq [7];
      seq = '{e(1, S_FETCH, C_FETCH_R), e(1, S_DECODE, C_DECODE), e(1, S_MEMADR, C_MEMADR),
              e(0, S_MEMRD, C_MEMRD), e(0, S_MEMRD, C_MEMRD), e(0, S_MEMRD, C_MEMRD),
              e(1, S_MEMRD, C_MEMRD)};
      opCode = OP_LOAD;
      foreach (seq[i]) begin
         mem_ready = seq[i][19];
         #1;
         n_total++;
         if ({state_dbg, ctrl1} !== seq[i][18:0])
            $display("FAIL lw_wait step%0d: got st=%0d ctrl=%b, want st=%0d ctrl=%b",
                     i, state_dbg, ctrl1, seq[i][18:15], seq[i][14:0]);
         else n_pass++;
         @(negedge clk);
      end
      mem_ready = 1'b1;
      #1;
      n_total++;
      if ({state_dbg, ctrl1, bus_err} !== {4'(S_MEMWB), C_MEMWB, 1'b0})
         $display("FAIL lw_writeback: got st=%0d ctrl=%b berr=%b, want st=%0d ctrl=%b berr=0",
                  state_dbg, ctrl1, bus_err, 4'(S_MEMWB), C_MEMWB);
      else n_pass++;
      @(negedge clk);
   endtask

   task automatic test_jalr();
      logic [19:0] seq [5];
      seq = '{e(1, S_FETCH, C_FETCH_R), e(1, S_DECODE, C_DECODE), e(1, S_JALR_ADR, C_MEMADR),
              e(1, S_JAL, C_JAL), e(1, S_ALUWB, C_ALUWB)};
      opCode = OP_JALR;
      foreach (seq[i]) begin
         mem_ready = seq[i][19];
         #1;
         n_total++;
         if ({state_dbg, ctrl1, immSel} !== {seq[i][18:0], 3'b000})
            $display("FAIL jalr step%0d: got st=%0d ctrl=%b imm=%b, want st=%0d ctrl=%b imm=000",
                     i, state_dbg, ctrl1, immSel, seq[i][18:15], seq[i][14:0]);
         else n_pass++;
         @(negedge clk);
      end
   endtask

   task automatic test_branch();
      logic [19:0] seq [3];
      seq = '{e(1, S_FETCH, C_FETCH_R), e(1, S_DECODE, C_DECODE), e(1, S_BRANCH, C_BRANCH)};
      opCode = OP_BRANCH;
      foreach (seq[i]) begin
         mem_ready = seq[i][19];
         #1;
         n_total++;
         if ({state_dbg, ctrl1, immSel} !== {seq[i][18:0], 3'b010})
            $display("FAIL branch step%0d: got st=%0d ctrl=%b imm=%b, want st=%0d ctrl=%b imm=010",
                     i, state_dbg, ctrl1, immSel, seq[i][18:15], seq[i][14:0]);
         else n_pass++;
         @(negedge clk);
      end
   endtask

   task automatic test_upper();
      logic [19:0] seq [8];
      logic [6:0]  ops [8];
      seq = '{e(1, S_FETCH, C_FETCH_R), e(1, S_DECODE, C_DECODE), e(1, S_UPPER, C_LUI),
              e(1, S_ALUWB, C_ALUWB), e(1, S_FETCH, C_FETCH_R), e(1, S_DECODE, C_DECODE),
              e(1, S_UPPER, C_AUIPC), e(1, S_ALUWB, C_ALUWB)};
      ops = '{OP_LUI, OP_LUI, OP_LUI, OP_LUI, OP_AUIPC, OP_AUIPC, OP_AUIPC, OP_AUIPC};
      foreach (seq[i]) begin
         opCode = ops[i];
         mem_ready = seq[i][19];
         #1;
         n_total++;
         if ({state_dbg, ctrl1, immSel} !== {seq[i][18:0], 3'b011})
            $display("FAIL upper step%0d: got st=%0d ctrl=%b imm=%b, want st=%0d ctrl=%b imm=011",
                     i, state_dbg, ctrl1, immSel, seq[i][18:15], seq[i][14:0]);
         else n_pass++;
         @(negedge clk);
      end
   endtask

   // Ready lands exactly on the cycle the timer reaches its limit.
   task automatic test_timeout_race();
      logic [19:0] q [$];
      q.push_back(e(1, S_FETCH, C_FETCH_R));
      q.push_back(e(1, S_DECODE, C_DECODE));
      q.push_back(e(1, S_MEMADR, C_MEMADR));
      for (int k = 0; k < 15; k++) q.push_back(e(0, S_MEMWR, C_MEMWR));
      q.push_back(e(1, S_MEMWR, C_MEMWR));
      q.push_back(e(1, S_FETCH, C_FETCH_R));
      opCode = OP_STORE;
      foreach (q[i]) begin
         mem_ready = q[i][19];
         #1;
         n_total++;
         if ({state_dbg, ctrl1} !== q[i][18:0])
            $display("FAIL timeout_race step%0d: got st=%0d ctrl=%b, want st=%0d ctrl=%b",
                     i, state_dbg, ctrl1, q[i][18:15], q[i][14:0]);
         else n_pass++;
         @(negedge clk);
      end
      n_total++;
      if (bus_err !== 1'b0)
         $display("FAIL timeout_race_err: got bus_err=%b, want 0", bus_err);
      else n_pass++;
   endtask

   task automatic test_sw_timeout();
      logic [19:0] q [$];
      q.push_back(e(1, S_DECODE, C_DECODE));
      q.push_back(e(1, S_MEMADR, C_MEMADR));
      for (int k = 0; k < 16; k++) q.push_back(e(0, S_MEMWR, C_MEMWR));
      for (int k = 0; k < 3; k++)  q.push_back(e(1, S_TRAP, C_ZERO));
      opCode = OP_STORE;
      foreach (q[i]) begin
         mem_ready = q[i][19];
         #1;
         n_total++;
         if ({state_dbg, ctrl1} !== q[i][18:0])
            $display("FAIL sw_timeout step%0d: got st=%0d ctrl=%b, want st=%0d ctrl=%b",
                     i, state_dbg, ctrl1, q[i][18:15], q[i][14:0]);
         else n_pass++;
         @(negedge clk);
      end
      n_total++;
      if ({bus_err, illegal, immSel} !== {1'b1, 1'b0, 3'b001})
         $display("FAIL sw_timeout_flags: got berr=%b ill=%b imm=%b, want berr=1 ill=0 imm=001",
                  bus_err, illegal, immSel);
      else n_pass++;
      rst = 1'b1;
      #1;
      n_total++;
      if ({state_dbg, ctrl1} !== {4'(S_FETCH), C_ZERO})
         $display("FAIL trap_rst_cycle: got st=%0d ctrl=%b, want st=0 ctrl=0", state_dbg, ctrl1);
      else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_total++;
      if ({state_dbg, ctrl1, bus_err} !== {4'(S_FETCH), C_FETCH_R, 1'b0})
         $display("FAIL trap_rst_clear: got st=%0d ctrl=%b berr=%b, want st=0 ctrl=%b berr=0",
                  state_dbg, ctrl1, bus_err, C_FETCH_R);
      else n_pass++;
      apply_reset();
   endtask

   task automatic test_illegal();
      logic [19:0] seq [5];
      logic [3:0]  st_nop [5];
      seq = '{e(1, S_FETCH, C_FETCH_R), e(1, S_DECODE, C_DECODE), e(1, S_TRAP, C_ZERO),
              e(1, S_TRAP, C_ZERO), e(1, S_TRAP, C_ZERO)};
      st_nop = '{4'(S_FETCH), 4'(S_DECODE), 4'(S_FETCH), 4'(S_DECODE), 4'(S_FETCH)};
      opCode = 7'b1111111;
      foreach (seq[i]) begin
         mem_ready = seq[i][19];
         #1;
         n_total++;
         if ({state_dbg, ctrl1, state_dbg2} !== {seq[i][18:0], st_nop[i]})
            $display("FAIL illegal step%0d: got st=%0d ctrl=%b st_nop=%0d, want st=%0d ctrl=%b st_nop=%0d",
                     i, state_dbg, ctrl1, state_dbg2, seq[i][18:15], seq[i][14:0], st_nop[i]);
         else n_pass++;
         @(negedge clk);
      end
      n_total++;
      if ({illegal, bus_err, illegal2} !== 3'b100)
         $display("FAIL illegal_flags: got ill=%b berr=%b ill_nop=%b, want 1 0 0",
                  illegal, bus_err, illegal2);
      else n_pass++;
      apply_reset();
   endtask

   task automatic test_rst_mid();
      logic [19:0] seq [4];
      seq = '{e(1, S_FETCH, C_FETCH_R), e(1, S_DECODE, C_DECODE), e(1, S_MEMADR, C_MEMADR),
              e(1, S_MEMRD, C_MEMRD)};
      opCode = OP_LOAD;
      foreach (seq[i]) begin
         mem_ready = seq[i][19];
         #1;
         n_total++;
         if ({state_dbg, ctrl1} !== seq[i][18:0])
            $display("FAIL rst_mid step%0d: got st=%0d ctrl=%b, want st=%0d ctrl=%b",
                     i, state_dbg, ctrl1, seq[i][18:15], seq[i][14:0]);
         else n_pass++;
         @(negedge clk);
      end
      rst = 1'b1;
      #1;
      n_total++;
      if ({state_dbg, ctrl1, RegWrite} !== {4'(S_FETCH), C_ZERO, 1'b0})
         $display("FAIL rst_mid_abort: got st=%0d ctrl=%b rw=%b, want st=0 ctrl=0 rw=0",
                  state_dbg, ctrl1, RegWrite);
      else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_total++;
      if ({state_dbg, ctrl1} !== {4'(S_FETCH), C_FETCH_R})
         $display("FAIL rst_mid_fetch: got st=%0d ctrl=%b, want st=0 ctrl=%b",
                  state_dbg, ctrl1, C_FETCH_R);
      else n_pass++;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_r_type();
      test_lw_wait();
      test_jalr();
      test_branch();
      test_upper();
      test_timeout_race();
      test_sw_timeout();
      test_illegal();
      test_rst_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
